vga_text_console: RTL and testbench
===================================

// Module: vga_text_console
// PURPOSE
//  Character-stream terminal engine upstream of the 80x60 monochrome text VGA scanner.
//  Accepts one byte per valid/ready handshake and writes glyph codes into the character area of vmem.
//  Tracks the cursor and interprets CR, LF, BS and FF; scrolls the screen up by one row when output passes row 59.
//  Drives the CPU-side vmem port; the scanner reads the other vmem port unchanged.
// PARAMETERS
//  VMEMSTART       1024  vmem address of character cell (0,0)
//  COLS            80    characters per row
//  ROWS            60    character rows
//  FILL_CHAR       8'h20 byte written by clear and scroll-fill
//  CLEAR_ON_RESET  1     1: run a full-screen clear after rst is released
// PORTS
//  clk         in   1   system clock (100MHz)
//  rst         in   1   reset, synchronous, active-low
//  char_in     in   8   byte to emit; bit7 = blink-inverse attribute, stored verbatim
//  char_valid  in   1   char_in valid
//  char_ready  out  1   engine idle; byte accepted when char_valid & char_ready
//  vmem_raddr  out  13  vmem read address (used only for scroll)
//  vmem_rdata  in   8   vmem read data, valid 1 cycle after vmem_raddr
//  vmem_waddr  out  13  vmem write address
//  vmem_wdata  out  8   vmem write data
//  vmem_we     out  1   vmem write strobe, one byte per cycle
//  cursor_col  out  7   current column, 0..COLS-1
//  cursor_row  out  6   current row, 0..ROWS-1
//  busy        out  1   ~char_ready
// BEHAVIOUR
//  Reset values (rst=0 sampled):
//   - vmem_we=0; waddr/raddr=VMEMSTART; wdata=0; cursor=(0,0); rowbase=VMEMSTART.
//   - char_ready=0 if CLEAR_ON_RESET, else 1.
//   - Reset mid-scroll or mid-clear aborts immediately; no further writes.
//  Maintain rowbase = VMEMSTART + row*COLS incrementally (+COLS per row); no multiplier.
//  States:
//   - S_IDLE: char_ready=1. On accept, dispatch on char_in[6:0] (bit7 ignored for control decode):
//       0x0D CR -> col=0, stay IDLE.
//       0x0A LF -> if row<ROWS-1 row++ (col kept), else S_SCROLL.
//       0x08 BS -> if col>0 col--, else no-op. Nothing erased.
//       0x0C FF -> S_CLEAR.
//       any other -> S_PUT.
//   - S_PUT (1 cycle): we=1, waddr=rowbase+col, wdata=char_in as latched at accept.
//       col<COLS-1 -> col++, IDLE.
//       col==COLS-1, row<ROWS-1 -> col=0, row++, IDLE.
//       col==COLS-1, row==ROWS-1 -> col=0, S_SCROLL.
//   - S_SCROLL: pipelined copy.
//       Cycle k issues raddr=src (src from VMEMSTART+COLS up to VMEMSTART+ROWS*COLS-1).
//       Cycle k+1 writes waddr=src-COLS, wdata=vmem_rdata.
//       One byte/cycle; 4720 writes; then S_FILL over the last row.
//       Cursor ends at (col unchanged by LF / 0 after wrap, ROWS-1).
//   - S_FILL: 80 writes of FILL_CHAR to the last row -> IDLE.
//   - S_CLEAR: 4800 writes of FILL_CHAR from VMEMSTART -> cursor (0,0), rowbase=VMEMSTART, IDLE.
//       Also entered from reset when CLEAR_ON_RESET=1.
//  Latency:
//   - Printable char: write 1 cycle after accept; char_ready returns the cycle after the write.
//   - Scroll busy = 4720+1+80 cycles.
//   - Clear busy = 4800 cycles.
//  Writes never leave [VMEMSTART, VMEMSTART+COLS*ROWS-1]; font area 0..1023 is never written.
//  char_valid while busy: held by producer, no loss, no duplicate.
// STRUCTURE
//  Shared package vga_pkg:
//   - VMEMSTART, COLS, ROWS, ASCII_CR/LF/BS/FF, state encodings S_IDLE..S_CLEAR.
//   - Shared with the VGA scanner.
//  One sub-module, vmem_blit: counter-driven copy/fill engine.
//   - Inputs: src, dst, len, fill_mode, fill_byte, start.
//   - Output: done.
//   - Owns the raddr/waddr/we pipeline.
//  Cursor/dispatch FSM stays in vga_text_console.
// TESTING (vmem modelled as 8K x 8 RAM, 1-cycle read)
//  1. Reset, CLEAR_ON_RESET=1 -> ready after 4800 writes; all of 1024..5823 = 0x20; 0..1023 untouched.
//  2. Send 'A','B' -> vmem[1024]=0x41, vmem[1025]=0x42; cursor (2,0); one we pulse per byte.
//  3. 81 x 'x' from (0,0) -> 1024..1104 = 0x78; cursor (1,1).
//  4. Row r preloaded with r+0x30 at (0,59), send LF -> row r holds r+0x31 for r<59;
//     row 59 all 0x20; cursor (0,59); busy for 4801 cycles.
//  5. At (5,3), send 0x88 -> treated as BS (bit7 ignored for decode): cursor (4,3).
//     Then send 0xC1 -> vmem[1024+3*80+4]=0xC1.
//  6. Assert rst mid-scroll (cycle 2000) -> vmem_we=0 next cycle; cursor (0,0); clear restarts on release.

Source files
------------

// File: rtl/vga_pkg.sv
// Constants and state encodings shared by the text console and the VGA scanner.
// Geometry here must match the scanner's character-area layout in vmem.
package vga_pkg;
  localparam int VMEMSTART = 1024;
  localparam int COLS      = 80;
  localparam int ROWS      = 60;

  localparam logic [6:0] ASCII_BS = 7'h08;
  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_FF = 7'h0C;
  localparam logic [6:0] ASCII_CR = 7'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_SCROLL,
    S_FILL,
    S_CLEAR
  } state_t;
endpackage

// File: rtl/vmem_blit.sv
// Copy/fill engine on the CPU-side vmem port: fill writes begin the cycle after start,
// copy writes trail their reads by one cycle; done marks the cycle of the final write.
module vmem_blit
  import vga_pkg::*;
#(
  parameter int         VMEMSTART      = 1024,
  parameter int         AREA           = 4800,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fill_mode,
  input  logic [12:0] src,
  input  logic [12:0] dst,
  input  logic [12:0] len,
  input  logic [7:0]  fill_byte,
  output logic        done,
  output logic [12:0] vmem_raddr,
  input  logic [7:0]  vmem_rdata,
  output logic [12:0] vmem_waddr,
  output logic [7:0]  vmem_wdata,
  output logic        vmem_we
);
  logic        active;
  logic        fill_q;
  logic [7:0]  byte_q;
  logic [12:0] src_ptr;
  logic [12:0] dst_ptr;
  logic [12:0] cnt;
  logic        we_q;
  logic        copy_q;
  logic        last_q;
  logic [12:0] waddr_q;
  logic [12:0] raddr_q;
  logic [7:0]  wdata_q;

  // Reset arms a full-area fill so the power-on clear starts on the first live cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= CLEAR_ON_RESET;
      fill_q  <= 1'b1;
      byte_q  <= FILL_CHAR;
      src_ptr <= 13'(VMEMSTART);
      dst_ptr <= 13'(VMEMSTART);
      cnt     <= 13'(AREA);
      we_q    <= 1'b0;
      copy_q  <= 1'b0;
      last_q  <= 1'b0;
      waddr_q <= 13'(VMEMSTART);
      raddr_q <= 13'(VMEMSTART);
      wdata_q <= 8'h00;
    end else if (start) begin
      fill_q <= fill_mode;
      byte_q <= fill_byte;
      copy_q <= 1'b0;
      cnt    <= len - 13'd1;
      if (fill_mode) begin
        we_q    <= 1'b1;
        waddr_q <= dst;
        wdata_q <= fill_byte;
        dst_ptr <= dst + 13'd1;
        last_q  <= (len == 13'd1);
        active  <= (len != 13'd1);
      end else begin
        we_q    <= 1'b0;
        last_q  <= 1'b0;
        raddr_q <= src;
        src_ptr <= src + 13'd1;
        dst_ptr <= dst;
        active  <= 1'b1;
      end
    end else if (active && fill_q) begin
      we_q    <= 1'b1;
      waddr_q <= dst_ptr;
      wdata_q <= byte_q;
      dst_ptr <= dst_ptr + 13'd1;
      cnt     <= cnt - 13'd1;
      last_q  <= (cnt == 13'd1);
      active  <= (cnt != 13'd1);
    end else if (active) begin
      // Each cycle writes the byte read last cycle and issues the next read.
      we_q    <= 1'b1;
      copy_q  <= 1'b1;
      waddr_q <= dst_ptr;
      dst_ptr <= dst_ptr + 13'd1;
      last_q  <= (cnt == 13'd0);
      if (cnt != 13'd0) begin
        raddr_q <= src_ptr;
        src_ptr <= src_ptr + 13'd1;
        cnt     <= cnt - 13'd1;
      end else begin
        active <= 1'b0;
      end
    end else begin
      we_q   <= 1'b0;
      copy_q <= 1'b0;
      last_q <= 1'b0;
    end
  end

  assign vmem_we    = we_q;
  assign vmem_waddr = waddr_q;
  assign vmem_raddr = raddr_q;
  assign vmem_wdata = copy_q ? vmem_rdata : wdata_q;
  assign done       = last_q;
endmodule

// File: rtl/vga_text_console.sv
// Byte-stream terminal writing glyphs into vmem: printable byte written 1 cycle after accept;
// char_ready drops for every multi-cycle operation and the producer holds char_valid meanwhile.
module vga_text_console #(
  parameter int         VMEMSTART      = vga_pkg::VMEMSTART,
  parameter int         COLS           = vga_pkg::COLS,
  parameter int         ROWS           = vga_pkg::ROWS,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [12:0] vmem_raddr,
  input  logic [7:0]  vmem_rdata,
  output logic [12:0] vmem_waddr,
  output logic [7:0]  vmem_wdata,
  output logic        vmem_we,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);
  import vga_pkg::*;

  localparam logic [12:0] BASE      = 13'(VMEMSTART);
  localparam logic [12:0] STRIDE    = 13'(COLS);
  localparam logic [12:0] AREA      = 13'(COLS * ROWS);
  localparam logic [12:0] LAST_BASE = 13'(VMEMSTART + (ROWS - 1) * COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);

  state_t      state, next_state;
  logic [6:0]  col;
  logic [5:0]  row;
  logic [12:0] rowbase;
  logic        accept;
  logic [6:0]  code;
  logic        at_end, at_bottom;
  logic        blit_start, blit_fill, blit_done;
  logic [12:0] blit_src, blit_dst, blit_len;
  logic [7:0]  blit_byte;

  assign char_ready = (state == S_IDLE);
  assign busy       = ~char_ready;
  assign accept     = char_valid & char_ready;
  assign code       = char_in[6:0];
  assign at_end     = (col == LAST_COL);
  assign at_bottom  = (row == LAST_ROW);
  assign cursor_col = col;
  assign cursor_row = row;

  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (code == ASCII_FF)                          next_state = S_CLEAR;
          else if (code == ASCII_LF)                     next_state = at_bottom ? S_SCROLL : S_IDLE;
          else if (code != ASCII_CR && code != ASCII_BS) next_state = S_PUT;
        end
      end
      S_PUT:          next_state = (at_end && at_bottom) ? S_SCROLL : S_IDLE;
      S_SCROLL:       if (blit_done) next_state = S_FILL;
      S_FILL, S_CLEAR: if (blit_done) next_state = S_IDLE;
      default:        next_state = S_IDLE;
    endcase
  end

  // Every entry into a writing state launches exactly one blit on the transition edge.
  always_comb begin
    blit_start = 1'b0;
    blit_fill  = 1'b1;
    blit_src   = BASE + STRIDE;
    blit_dst   = rowbase + {6'd0, col};
    blit_len   = 13'd1;
    blit_byte  = char_in;
    if (next_state != state) begin
      case (next_state)
        S_PUT: blit_start = 1'b1;
        S_SCROLL: begin
          blit_start = 1'b1;
          blit_fill  = 1'b0;
          blit_dst   = BASE;
          blit_len   = AREA - STRIDE;
        end
        S_FILL: begin
          blit_start = 1'b1;
          blit_dst   = LAST_BASE;
          blit_len   = STRIDE;
          blit_byte  = FILL_CHAR;
        end
        S_CLEAR: begin
          blit_start = 1'b1;
          blit_dst   = BASE;
          blit_len   = AREA;
          blit_byte  = FILL_CHAR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col     <= 7'd0;
      row     <= 6'd0;
      rowbase <= BASE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (code == ASCII_CR) begin
              col <= 7'd0;
            end else if (code == ASCII_LF && !at_bottom) begin
              row     <= row + 6'd1;
              rowbase <= rowbase + STRIDE;
            end else if (code == ASCII_BS && col != 7'd0) begin
              col <= col - 7'd1;
            end
          end
        end
        S_PUT: begin
          if (!at_end) begin
            col <= col + 7'd1;
          end else begin
            col <= 7'd0;
            if (!at_bottom) begin
              row     <= row + 6'd1;
              rowbase <= rowbase + STRIDE;
            end
          end
        end
        S_CLEAR: begin
          if (blit_done) begin
            col     <= 7'd0;
            row     <= 6'd0;
            rowbase <= BASE;
          end
        end
        default: ;
      endcase
    end
  end

  vmem_blit #(
    .VMEMSTART      (VMEMSTART),
    .AREA           (COLS * ROWS),
    .FILL_CHAR      (FILL_CHAR),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_blit (
    .clk        (clk),
    .rst        (rst),
    .start      (blit_start),
    .fill_mode  (blit_fill),
    .src        (blit_src),
    .dst        (blit_dst),
    .len        (blit_len),
    .fill_byte  (blit_byte),
    .done       (blit_done),
    .vmem_raddr (vmem_raddr),
    .vmem_rdata (vmem_rdata),
    .vmem_waddr (vmem_waddr),
    .vmem_wdata (vmem_wdata),
    .vmem_we    (vmem_we)
  );
endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: 8K x 8 vmem with 1-cycle read, screen-level terminal model.
module tb_vga_text_console;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [12:0] vmem_raddr;
  logic [7:0]  vmem_rdata;
  logic [12:0] vmem_waddr;
  logic [7:0]  vmem_wdata;
  logic        vmem_we;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  vga_text_console dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .vmem_raddr (vmem_raddr),
    .vmem_rdata (vmem_rdata),
    .vmem_waddr (vmem_waddr),
    .vmem_wdata (vmem_wdata),
    .vmem_we    (vmem_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  logic [7:0]  mem [0:8191];
  logic        bk_we = 1'b0;
  logic [12:0] bk_addr = 13'd0;
  logic [7:0]  bk_dat = 8'h00;
  int          wr_cnt = 0;
  int          oob_cnt = 0;

  always @(posedge clk) begin
    if (vmem_we) begin
      mem[vmem_waddr] <= vmem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (vmem_waddr < 13'd1024 || vmem_waddr > 13'd5823) oob_cnt <= oob_cnt + 1;
    end
    if (bk_we) mem[bk_addr] <= bk_dat;
    vmem_rdata <= mem[vmem_raddr];
  end

  // Reference terminal: a 60x80 screen image plus cursor.
  logic [7:0] scr [60][80];
  int mcol = 0, mrow = 0;
  int passed = 0, total = 0;

  function automatic logic [7:0] font_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++) scr[r][c] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < 59; r++)
      for (int c = 0; c < 80; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < 80; c++) scr[59][c] = 8'h20;
  endtask

  task automatic model_apply(input logic [7:0] b);
    case (b[6:0])
      7'h0D: mcol = 0;
      7'h0A: if (mrow < 59) mrow++; else model_scroll();
      7'h08: if (mcol > 0) mcol--;
      7'h0C: model_clear();
      default: begin
        scr[mrow][mcol] = b;
        if (mcol < 79) mcol++;
        else begin
          mcol = 0;
          if (mrow < 59) mrow++; else model_scroll();
        end
      end
    endcase
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic check_cursor(input string nm, input int c, input int r);
    check({nm, ".col"}, int'(cursor_col), c);
    check({nm, ".row"}, int'(cursor_row), r);
  endtask

  task automatic compare_screen(input string nm);
    int bad;
    bad = 0;
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        if (mem[1024 + r*80 + c] !== scr[r][c]) bad++;
    check(nm, bad, 0);
  endtask

  task automatic check_font(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== font_byte(i)) bad++;
    check(nm, bad, 0);
  endtask

  task automatic accept_byte(input logic [7:0] b, output int w0);
    int n;
    n = 0;
    @(negedge clk);
    char_in = b;
    char_valid = 1'b1;
    while (!char_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("accept_ready", int'(char_ready), 1);
    w0 = wr_cnt;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!char_ready && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    if (!char_ready) check("ready_timeout", int'(char_ready), 1);
  endtask

  task automatic send(input logic [7:0] b, output int bsy, output int nwr);
    int w0;
    accept_byte(b, w0);
    model_apply(b);
    wait_ready(bsy);
    nwr = wr_cnt - w0;
  endtask

  typedef struct {
    logic [7:0] b;
    int col;
    int row;
    int bsy;
    int nwr;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int bsy, nwr, w0;
    logic [7:0] b;
    int k;

    tbl[0] = '{8'h41, 1, 0, 1, 1};
    tbl[1] = '{8'h42, 2, 0, 1, 1};
    tbl[2] = '{8'h0D, 0, 0, 0, 0};
    tbl[3] = '{8'h0A, 0, 1, 0, 0};
    tbl[4] = '{8'h08, 0, 1, 0, 0};
    tbl[5] = '{8'h43, 1, 1, 1, 1};
    tbl[6] = '{8'h88, 0, 1, 0, 0};
    tbl[7] = '{8'hC1, 1, 1, 1, 1};
    tbl[8] = '{8'h8A, 1, 2, 0, 0};
    tbl[9] = '{8'h8D, 0, 2, 0, 0};

    // Load a font pattern while the DUT is held in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bk_we = 1'b1;
      bk_addr = 13'(i);
      bk_dat = font_byte(i);
    end
    @(negedge clk);
    bk_we = 1'b0;

    check("rst_we", int'(vmem_we), 0);
    check("rst_waddr", int'(vmem_waddr), 1024);
    check("rst_raddr", int'(vmem_raddr), 1024);
    check("rst_wdata", int'(vmem_wdata), 0);
    check_cursor("rst_cursor", 0, 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);

    w0 = wr_cnt;
    rst = 1'b1;
    wait_ready(bsy);
    check("por_clear_busy", bsy, 4800);
    check("por_clear_writes", wr_cnt - w0, 4800);
    model_clear();
    compare_screen("por_clear_screen");
    check_font("por_font");

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].b, bsy, nwr);
      check_cursor($sformatf("tbl%0d_cursor", i), tbl[i].col, tbl[i].row);
      check($sformatf("tbl%0d_busy", i), bsy, tbl[i].bsy);
      check($sformatf("tbl%0d_writes", i), nwr, tbl[i].nwr);
    end
    check("put_A", int'(mem[1024]), 8'h41);
    check("put_B", int'(mem[1025]), 8'h42);
    check("put_C1_row1", int'(mem[1104]), 8'hC1);
    compare_screen("tbl_screen");

    // Bit7 ignored for control decode; stored verbatim for glyphs.
    send(8'h0C, bsy, nwr);
    check("ff_busy", bsy, 4800);
    check("ff_writes", nwr, 4800);
    check_cursor("ff_cursor", 0, 0);
    for (int i = 0; i < 3; i++) send(8'h0A, bsy, nwr);
    for (int i = 0; i < 5; i++) send(8'h61, bsy, nwr);
    check_cursor("at_5_3", 5, 3);
    send(8'h88, bsy, nwr);
    check_cursor("bs_bit7", 4, 3);
    check("bs_no_erase", int'(mem[1268]), 8'h61);
    send(8'hC1, bsy, nwr);
    check("put_bit7", int'(mem[1268]), 8'hC1);
    check_cursor("after_C1", 5, 3);

    // Line wrap from the end of row 0.
    send(8'h0C, bsy, nwr);
    for (int i = 0; i < 81; i++) send(8'h78, bsy, nwr);
    check_cursor("wrap81", 1, 1);
    check("wrap_last", int'(mem[1104]), 8'h78);
    check("wrap_next", int'(mem[1105]), 8'h20);
    compare_screen("wrap_screen");

    // Scroll by LF on the last row, with rows preloaded to r+0x30.
    send(8'h0C, bsy, nwr);
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        bk_we = 1'b1;
        bk_addr = 13'(1024 + r*80 + c);
        bk_dat = 8'(r + 8'h30);
        scr[r][c] = 8'(r + 8'h30);
      end
    end
    @(negedge clk);
    bk_we = 1'b0;
    for (int i = 0; i < 59; i++) send(8'h0A, bsy, nwr);
    check_cursor("at_row59", 0, 59);
    send(8'h0A, bsy, nwr);
    check("scroll_busy", bsy, 4801);
    check("scroll_writes", nwr, 4800);
    check_cursor("scroll_cursor", 0, 59);
    check("scroll_row0", int'(mem[1024]), 8'h31);
    check("scroll_row58", int'(mem[1024 + 58*80 + 17]), 8'h6B);
    check("scroll_row59", int'(mem[5823]), 8'h20);
    compare_screen("scroll_screen");

    // Wrap off the bottom-right cell also scrolls.
    for (int i = 0; i < 79; i++) send(8'h79, bsy, nwr);
    send(8'h7A, bsy, nwr);
    check("wrap_scroll_writes", nwr, 4801);
    check_cursor("wrap_scroll_cursor", 0, 59);
    compare_screen("wrap_scroll_screen");

    // Randomized byte stream against the model.
    send(8'h0C, bsy, nwr);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 15);
      if (k < 2)       b = (k == 1) ? 8'h8A : 8'h0A;
      else if (k == 2) b = ($urandom_range(0, 1) == 1) ? 8'h8D : 8'h0D;
      else if (k == 3) b = ($urandom_range(0, 1) == 1) ? 8'h88 : 8'h08;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b[6:0] == 7'h0D || b[6:0] == 7'h0A || b[6:0] == 7'h08 || b[6:0] == 7'h0C)
          b = b ^ 8'h10;
      end
      send(b, bsy, nwr);
      check($sformatf("rand%0d_cursor", i), int'(cursor_row) * 256 + int'(cursor_col),
            mrow * 256 + mcol);
    end
    compare_screen("rand_screen");

    // Reset in the middle of a scroll aborts it and restarts the clear.
    while (mrow < 59) send(8'h0A, bsy, nwr);
    accept_byte(8'h0A, w0);
    repeat (2000) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_we", int'(vmem_we), 0);
    check_cursor("abort_cursor", 0, 0);
    check("abort_ready", int'(char_ready), 0);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    check("abort_no_writes", wr_cnt - w0, 0);
    rst = 1'b1;
    model_clear();
    w0 = wr_cnt;
    wait_ready(bsy);
    check("reclear_busy", bsy, 4800);
    check("reclear_writes", wr_cnt - w0, 4800);
    compare_screen("reclear_screen");
    check_font("final_font");
    check("out_of_range_writes", oob_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
